// File: rtl/lsu_mem_port.sv
// MEM-stage load/store initiator for a word-addressed async-read data memory.
// Optional LSU_ALIGN_CHECK_EN enables alignment/range/size error responses.
module lsu_mem_port #(
    parameter int XW = 32,
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [XW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACCESS   = 2'd1;
    localparam logic [1:0] S_MERGE_WR = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    // Handshake: a request is taken on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE outside reset.
    logic [1:0]    r_state;
    logic          r_store;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [1:0]    r_lane;
    logic [DW-1:0] r_wdata;
    logic          r_err;
    logic [DW-1:0] r_ld_data;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_wdata;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_rdata;
    logic          r_rsp_err;

    logic          w_accept;
    logic          w_err;
    logic [1:0]    w_size;
    logic [1:0]    w_lane;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_ld;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

`ifdef LSU_ALIGN_CHECK_EN
    assign w_size = req_size;
    assign w_lane = req_addr[1:0];
    assign w_err  = (|req_addr[XW-1:AW+2]) || (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    logic w_unused_addr;
    assign w_unused_addr = |req_addr[XW-1:AW+2];
    // Reserved size behaves as a word; misaligned lanes are rounded down.
    assign w_size = (req_size == 2'b11) ? 2'b10 : req_size;
    assign w_lane = (w_size == 2'b00) ? req_addr[1:0] :
                    (w_size == 2'b01) ? {req_addr[1], 1'b0} : 2'b00;
    assign w_err  = 1'b0;
`endif

    assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_merged = mem_rdata;
        if (r_size == 2'b00)
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_comb begin
        case (r_size)
            2'b00:   w_ld = {{(DW-8){!r_unsigned && w_byte[7]}}, w_byte};
            2'b01:   w_ld = {{(DW-16){!r_unsigned && w_half[15]}}, w_half};
            default: w_ld = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_ld_data   <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_store    <= req_store;
                        r_size     <= w_size;
                        r_unsigned <= req_unsigned;
                        r_lane     <= w_lane;
                        r_wdata    <= req_wdata;
                        r_err      <= w_err;
                        r_ld_data  <= '0;
                        if (w_err) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state    <= S_ACCESS;
                            r_mem_addr <= req_addr[AW+1:2];
                            if (req_store && w_size == 2'b10) begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_store) begin
                        r_ld_data <= w_ld;
                        r_state   <= S_RESP;
                    end else if (r_size == 2'b10) begin
                        r_mem_we <= 1'b0;
                        r_state  <= S_RESP;
                    end else begin
                        // Sub-word store: this cycle was the read half of RMW.
                        r_mem_wdata <= w_merged;
                        r_mem_we    <= 1'b1;
                        r_state     <= S_MERGE_WR;
                    end
                end
                S_MERGE_WR: begin
                    r_mem_we <= 1'b0;
                    r_state  <= S_RESP;
                end
                default: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_ld_data;
                    r_rsp_err   <= r_err;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: directed requests push expected responses
// and memory writes; negedge monitors pop and compare them with cycle timing.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [6:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:127];
    int cyc = 0;
    int n_acc = 0;
    int n_tests = 0;
    int n_fail = 0;

    // {cycle[15:0], err, rdata}
    logic [48:0] exp_q[$];
    // {cycle[15:0], addr[6:0], data}
    logic [54:0] wr_q[$];

    always #5 clk = ~clk;

    lsu_mem_port dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [48:0] e;
        logic [54:0] w;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_cycle", 64'(cyc[15:0]), 64'(e[48:33]));
                chk("rsp_err", 64'(rsp_err), 64'(e[32]));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL wr_unexpected: got mem_we=1 addr %0h expected none (cycle %0d)", mem_addr, cyc);
            end else begin
                w = wr_q.pop_front();
                chk("wr_cycle", 64'(cyc[15:0]), 64'(w[54:39]));
                chk("wr_addr", 64'(mem_addr), 64'(w[38:32]));
                chk("wr_data", 64'(mem_wdata), 64'(w[31:0]));
            end
        end
    end

    // lat: cycles from accept to rsp_valid; woff: cycles from accept to mem_we.
    task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic has_rsp, input logic [31:0] exp_rd,
                         input logic exp_err, input int lat,
                         input logic has_wr, input logic [6:0] wa,
                         input logic [31:0] wdat, input int woff, input logic hold);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
            req_valid = 1'b0;
            return;
        end
        req_valid = 1'b1; req_store = st; req_size = sz;
        req_unsigned = un; req_addr = ad; req_wdata = wd;
        @(posedge clk);
        #1;
        if (has_rsp) exp_q.push_back({16'(cyc + lat), exp_err, exp_rd});
        if (has_wr) wr_q.push_back({16'(cyc + woff), wa, wdat});
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic load(input logic [1:0] sz, input logic un, input logic [31:0] ad,
                        input logic [31:0] exp_rd);
        issue(1'b0, sz, un, ad, 32'h0, 1'b1, exp_rd, 1'b0, 2, 1'b0, 7'h0, 32'h0, 0, 1'b0);
    endtask

    task automatic store_w(input logic [31:0] ad, input logic [31:0] wd, input logic [6:0] wa);
        issue(1'b1, 2'b10, 1'b0, ad, wd, 1'b1, 32'h0, 1'b0, 2, 1'b1, wa, wd, 0, 1'b0);
    endtask

    task automatic store_sub(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                             input logic [6:0] wa, input logic [31:0] merged);
        issue(1'b1, sz, 1'b0, ad, wd, 1'b1, 32'h0, 1'b0, 3, 1'b1, wa, merged, 1, 1'b0);
    endtask

    initial begin
        int a0;
        int n;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_mem_we", 64'(mem_we), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("reset_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        store_w(32'h0, 32'h0, 7'd0);
        store_w(32'h14, 32'h0, 7'd5);
        store_w(32'h10, 32'hDEADBEEF, 7'd4);
        load(2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        store_w(32'h10, 32'h11223344, 7'd4);
        store_sub(2'b00, 32'h12, 32'h000000AA, 7'd4, 32'h11AA3344);
        load(2'b00, 1'b0, 32'h12, 32'hFFFFFFAA);
        load(2'b00, 1'b1, 32'h12, 32'h000000AA);
        load(2'b01, 1'b0, 32'h12, 32'h000011AA);
        store_sub(2'b01, 32'h16, 32'hFFFF8001, 7'd5, 32'h80010000);
        load(2'b01, 1'b0, 32'h16, 32'hFFFF8001);
        load(2'b01, 1'b1, 32'h16, 32'h00008001);
        load(2'b00, 1'b1, 32'h17, 32'h00000080);
        store_sub(2'b00, 32'h14, 32'h1234565A, 7'd5, 32'h8001005A);
        load(2'b10, 1'b0, 32'h14, 32'h8001005A);

`ifdef LSU_ALIGN_CHECK_EN
        issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0, 7'h0, 32'h0, 0, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1, 1, 1'b0, 7'h0, 32'h0, 0, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0, 7'h0, 32'h0, 0, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h15, 32'hBEEF, 1'b1, 32'h0, 1'b1, 1, 1'b0, 7'h0, 32'h0, 0, 1'b0);
        load(2'b10, 1'b0, 32'h0, 32'h0);
        load(2'b10, 1'b0, 32'h14, 32'h8001005A);
`else
        load(2'b10, 1'b0, 32'h13, 32'h11AA3344);
        load(2'b01, 1'b0, 32'h13, 32'h000011AA);
        load(2'b11, 1'b0, 32'h10, 32'h11AA3344);
        store_w(32'h216, 32'h12345678, 7'd5);
        load(2'b10, 1'b0, 32'h14, 32'h12345678);
`endif

        // Held req_valid: exactly one accept per 3-cycle load transaction.
        a0 = n_acc;
        for (int i = 0; i < 3; i++)
            issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11AA3344, 1'b0, 2,
                  1'b0, 7'h0, 32'h0, 0, 1'b1);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("held_accepts", 64'(n_acc - a0), 64'd3);

        // Reset during MERGE_WR: one write only, no response.
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000077, 1'b0, 32'h0, 1'b0, 0,
              1'b1, 7'd4, 32'h11AA7744, 1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mid_state", 64'(dbg_state), 64'd0);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        load(2'b10, 1'b0, 32'h10, 32'h11AA7744);
        load(2'b00, 1'b0, 32'h11, 32'h00000077);

        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 30) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk("rsp_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
